// File: rtl/ucsbece154b_rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package ucsbece154b_rf_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Highest set bit of a write-hit vector (youngest slot), or -1 when no slot hits.
    function automatic int hi_slot(input logic [31:0] hits);
        int sel = -1;
        for (int s = 0; s < 32; s++) begin
            if (hits[s]) sel = s;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ucsbece154b_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared at its writeback.
module ucsbece154b_scoreboard
    import ucsbece154b_rf_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int NW   = 2,
    localparam int AW  = clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NW-1:0]    iss_i,
    input  logic [NW*AW-1:0] ia_i,
    input  logic [NW-1:0]    we_i,
    input  logic [NW*AW-1:0] wa_i,
    output logic [NREG-1:0]  busy_o
);

    logic [NREG-1:0] set_v;
    logic [NREG-1:0] clr_v;
    logic [NREG-1:0] busy_next;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int s = 0; s < NW; s++) begin
            if (iss_i[s]) set_v[ia_i[s*AW +: AW]] = 1'b1;
            if (we_i[s])  clr_v[wa_i[s*AW +: AW]] = 1'b1;
        end
        // A new issue wins over a same-cycle writeback of the older producer.
        busy_next    = set_v | (busy_o & ~clr_v);
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) busy_o <= '0;
        else          busy_o <= busy_next;
    end

endmodule

// File: rtl/ucsbece154b_rf_mp.sv
// Parametrised multi-port register file with write bypass, youngest-slot write
// priority, busy scoreboard and a sticky same-address write collision flag.
module ucsbece154b_rf_mp
    import ucsbece154b_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int NW     = 2,
    parameter int NR     = 4,
    parameter int BYPASS = 1,
    localparam int AW    = clog2(NREG)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NR*AW-1:0]   ra_i,
    output logic [NR*XLEN-1:0] rd_o,
    output logic [NR-1:0]      rdy_o,
    input  logic [NW-1:0]      we_i,
    input  logic [NW*AW-1:0]   wa_i,
    input  logic [NW*XLEN-1:0] wd_i,
    input  logic [NW-1:0]      iss_i,
    input  logic [NW*AW-1:0]   ia_i,
    output logic [NREG-1:0]    busy_o,
    output logic               conflict_o
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [XLEN-1:0] regs [NREG];
    logic            collide;

    ucsbece154b_scoreboard #(.NREG(NREG), .NW(NW)) u_sb (
        .clk     (clk),
        .reset_n (reset_n),
        .iss_i   (iss_i),
        .ia_i    (ia_i),
        .we_i    (we_i),
        .wa_i    (wa_i),
        .busy_o  (busy_o)
    );

    // Ascending slot order makes the youngest slot's write land last.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int s = 0; s < NW; s++) begin
                if (we_i[s] && (wa_i[s*AW +: AW] != ZERO))
                    regs[wa_i[s*AW +: AW]] <= wd_i[s*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int s = 0; s < NW; s++) begin
            for (int t = s + 1; t < NW; t++) begin
                if (we_i[s] && we_i[t] && (wa_i[s*AW +: AW] == wa_i[t*AW +: AW])
                    && (wa_i[s*AW +: AW] != ZERO))
                    collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)     conflict_o <= 1'b0;
        else if (collide) conflict_o <= 1'b1;
    end

    always_comb begin
        logic [AW-1:0] addr;
        logic [31:0]   hits;
        int            sel;
        rd_o  = '0;
        rdy_o = '0;
        for (int k = 0; k < NR; k++) begin
            addr = ra_i[k*AW +: AW];
            hits = '0;
            for (int s = 0; s < NW; s++) begin
                hits[s] = we_i[s] && (wa_i[s*AW +: AW] == addr) && (addr != ZERO);
            end
            sel = hi_slot(hits);
            if (addr == ZERO)
                rd_o[k*XLEN +: XLEN] = '0;
            else if ((BYPASS != 0) && (sel >= 0))
                rd_o[k*XLEN +: XLEN] = wd_i[sel*XLEN +: XLEN];
            else
                rd_o[k*XLEN +: XLEN] = regs[addr];
            rdy_o[k] = ~busy_o[addr] | ((BYPASS != 0) && (hits != '0));
        end
    end

endmodule
